// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial subtractor, one full-subtractor cell reused LSB-first across WIDTH cycles
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sh, b_sh, diff_nx;
  logic [CW-1:0] cnt;
  logic borrow, d, bo;
  assign d = a_sh[0] ^ b_sh[0] ^ borrow;
  assign bo = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
  assign busy = state == RUN;
  assign done = state == DONE;
  // Shifting the new bit in from the MSB end leaves bit 0 of the result at diff[0] after WIDTH steps
  always_comb begin
    diff_nx = diff >> 1;
    diff_nx[WIDTH-1] = d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      borrow <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        a_sh <= a_in;
        b_sh <= b_in;
        borrow <= bin_in;
        cnt <= '0;
        diff <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      diff <= diff_nx;
      borrow <= bo;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        bout <= bo;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: scoreboard bench over WIDTH=8, 4 and 1 instances
module tb_serial_subtractor_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic s8 = 0, s4 = 0, s1 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic a1 = 0, b1 = 0, bi8 = 0, bi4 = 0, bi1 = 0;
  logic busy8, done8, bout8, busy4, done4, bout4, busy1, done1, bout1;
  logic [7:0] diff8;
  logic [3:0] diff4;
  logic diff1;
  int checks = 0;
  int errors = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [1:0] q1[$];
  logic pd8 = 0, pd4 = 0, pd1 = 0;

  serial_subtractor_ctrl #(.WIDTH(8), .CW(6)) u8 (.clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8),
    .bin_in(bi8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
  serial_subtractor_ctrl #(.WIDTH(4), .CW(3)) u4 (.clk(clk), .rst(rst), .start(s4), .a_in(a4), .b_in(b4),
    .bin_in(bi4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));
  serial_subtractor_ctrl #(.WIDTH(1), .CW(1)) u1 (.clk(clk), .rst(rst), .start(s1), .a_in(a1), .b_in(b1),
    .bin_in(bi1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected {bout,diff} on every done pulse, and require done to last one cycle
  always @(negedge clk) begin
    if (done8) begin
      chk("w8_done_width", 32'(pd8), 0);
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_unexpected_done: got %0h expected no result", {bout8, diff8});
      end else chk("w8_result", {bout8, diff8}, q8.pop_front());
    end
    pd8 = done8;
  end
  always @(negedge clk) begin
    if (done4) begin
      chk("w4_done_width", 32'(pd4), 0);
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL w4_unexpected_done: got %0h expected no result", {bout4, diff4});
      end else chk("w4_result", {bout4, diff4}, q4.pop_front());
    end
    pd4 = done4;
  end
  always @(negedge clk) begin
    if (done1) begin
      chk("w1_done_width", 32'(pd1), 0);
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL w1_unexpected_done: got %0h expected no result", {bout1, diff1});
      end else chk("w1_result", {bout1, diff1}, q1.pop_front());
    end
    pd1 = done1;
  end

  function automatic logic busy_of(int s);
    return s == 0 ? busy8 : s == 1 ? busy4 : busy1;
  endfunction
  function automatic logic done_of(int s);
    return s == 0 ? done8 : s == 1 ? done4 : done1;
  endfunction
  function automatic int width_of(int s);
    return s == 0 ? 8 : s == 1 ? 4 : 1;
  endfunction

  // One operation on instance s; checks busy for WIDTH cycles then done in cycle WIDTH+1
  task automatic op(int s, logic [7:0] a, logic [7:0] b, logic bi, logic [8:0] exp);
    int w = width_of(s);
    int n = 1;
    @(negedge clk);
    if (s == 0) begin a8 = a; b8 = b; bi8 = bi; s8 = 1; q8.push_back(exp); end
    else if (s == 1) begin a4 = a[3:0]; b4 = b[3:0]; bi4 = bi; s4 = 1; q4.push_back(exp[4:0]); end
    else begin a1 = a[0]; b1 = b[0]; bi1 = bi; s1 = 1; q1.push_back(exp[1:0]); end
    @(negedge clk);
    s8 = 0; s4 = 0; s1 = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); bi8 = 1'($urandom); bi4 = 1'($urandom); bi1 = 1'($urandom);
    while (!done_of(s) && n <= w + 4) begin
      if (n <= w) chk("busy_run", 32'(busy_of(s)), 1);
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, w + 1);
    chk("busy_in_done", 32'(busy_of(s)), 0);
  endtask

  logic [1:0] w1_exp[8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] ra, rb;
    logic rbi;
    logic [2:0] v;
    repeat (3) @(negedge clk);
    chk("rst_busy", {busy8, busy4, busy1}, 0);
    chk("rst_done", {done8, done4, done1}, 0);
    chk("rst_diff8", {bout8, diff8}, 0);
    chk("rst_diff4", {bout4, diff4}, 0);
    rst = 0;
    op(1, 8'd9, 8'd3, 1'b0, 9'h006);
    op(1, 8'd3, 8'd9, 1'b0, 9'h01A);
    op(1, 8'd0, 8'd0, 1'b1, 9'h01F);
    op(1, 8'd15, 8'd0, 1'b0, 9'h00F);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      op(2, {7'd0, v[2]}, {7'd0, v[1]}, v[0], {7'd0, w1_exp[i]});
    end
    op(0, 8'h80, 8'h01, 1'b0, 9'h07F);
    op(0, 8'h00, 8'hFF, 1'b1, 9'h100);
    op(0, 8'hFF, 8'h00, 1'b0, 9'h0FF);
    // start held high: second op accepted exactly WIDTH+2 edges after the first
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd55; bi8 = 0; s8 = 1;
    q8.push_back(9'h091);
    q8.push_back(9'h1FF);
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd2;
    for (int i = 1; i <= 8; i++) begin
      chk("hold_busy", 32'(busy8), 1);
      @(negedge clk);
    end
    chk("hold_done", 32'(done8), 1);
    @(negedge clk);
    chk("hold_idle", {busy8, done8}, 0);
    @(negedge clk);
    chk("hold_reaccept", 32'(busy8), 1);
    s8 = 0;
    n = 0;
    while (!done8 && n < 12) begin @(negedge clk); n++; end
    chk("hold_second_latency", n, 8);
    // reset during the third RUN cycle aborts without a done pulse
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; s8 = 1;
    @(negedge clk);
    s8 = 0;
    chk("abort_busy", 32'(busy8), 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_busy_clr", {busy8, done8}, 0);
    chk("abort_result_clr", {bout8, diff8}, 0);
    rst = 0;
    repeat (12) @(negedge clk);
    op(0, 8'h80, 8'h01, 1'b0, 9'h07F);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(0, ra, rb, rbi, 9'(int'(ra) - int'(rb) - int'(rbi)));
    end
    repeat (5) @(negedge clk);
    chk("queues_drained", q8.size() + q4.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It sequences a single full-subtractor cell (diff = a^b^bin, bout = (~a&b) | (~(a^b)&bin)) across WIDTH bit positions, LSB first, carrying the borrow in a register between cycles. It accepts operands through a start/busy/done handshake and returns the WIDTH-bit difference plus the final borrow. It serves area-constrained paths where a ripple subtractor of full width is not justified.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32
CW, 6, counter width; must satisfy 2**CW > WIDTH

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  minuend, captured on accepted start
b_in  input  WIDTH  subtrahend, captured on accepted start
bin_in  input  1  initial borrow-in, captured on accepted start
busy  output  1  high while bits are being processed (RUN state)
done  output  1  one-cycle pulse: result valid
diff  output  WIDTH  difference a_in - b_in - bin_in, modulo 2**WIDTH
bout  output  1  final borrow-out; 1 when a_in < b_in + bin_in

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, internal shift/borrow regs=0. rst wins over every other input on the same edge.
- States: IDLE, RUN, DONE (2-bit encoding, unused code -> IDLE).
- IDLE: on edge with start=1: load a_sh<=a_in, b_sh<=b_in, borrow<=bin_in, cnt<=0, diff clears to 0, go RUN. start=0: stay.
- RUN: each edge processes bit cnt using a_sh[0], b_sh[0], borrow: result bit shifted into diff from the MSB end (diff<={d, diff[WIDTH-1:1]}), borrow<=bo, a_sh/b_sh shift right by 1, cnt<=cnt+1. On the edge processing cnt==WIDTH-1: bout<=bo, go DONE.
- DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
- Latency: start sampled at edge E0; busy=1 during cycles after E0..E(WIDTH); done=1 in the cycle after edge E(WIDTH); new start accepted at edge E(WIDTH+2) earliest. Throughput: one operation per WIDTH+2 cycles.
- busy is combinational from state (RUN only); done from state (DONE only); both glitch-free registered-state decodes.
- start while RUN or DONE is ignored; operands not re-sampled; no queuing.
- diff/bout hold their last completed value from DONE through IDLE until the next accepted start. diff is undefined-for-use (partial) while busy=1; bout holds the previous result until the final RUN edge.
- a_in/b_in/bin_in may change freely after the accepting edge without affecting the result.
- Reset mid-RUN: aborts, no done pulse, outputs to reset values on that edge.
- WIDTH=1: RUN lasts one cycle; behaviour equals one full-subtractor evaluation.
- Arithmetic: {bout, diff} equals the (WIDTH+1)-bit two's-complement of a_in - b_in - bin_in; bout=1 exactly when the true result is negative.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0, start 1 cycle -> busy high 4 cycles, done pulse in cycle 5, diff=6, bout=0.
- WIDTH=4, a=3, b=9, bin=0 -> diff=4'b1010 (10), bout=1; a=0, b=0, bin=1 -> diff=15, bout=1.
- WIDTH=1, all 8 {a,b,bin} combinations 0..7 -> {diff,bout} = 00,11,11,01,10,00,00,11; done after exactly 2 cycles each.
- WIDTH=8, start held high continuously with a=200, b=55 changed to a=1, b=2 one cycle after acceptance -> diff=145, bout=0; second op starts exactly at E(WIDTH+2) and yields the new operands' result.
- Reset asserted at third RUN cycle -> busy=0, done never pulses, diff=0, bout=0 next cycle; subsequent start a=0x80, b=0x01 -> diff=0x7F, bout=0.
- Random regression, WIDTH=8, 1000 ops with random gaps -> {bout,diff} matches reference model a-b-bin mod 512; done is exactly one cycle wide per accepted start.
